// File: rtl/matrix_pkg.sv
// Shared constants, loader state encoding and bus addressing for the matrix adder path.
// Both the loader and AddUnit size their buses from these constants.
package matrix_pkg;

   localparam int unsigned DIM_MAX   = 5;
   localparam int unsigned ELEM_W    = 8;
   localparam int unsigned MAT_W     = DIM_MAX * DIM_MAX * ELEM_W;
   localparam int unsigned BUS_W     = 2 * MAT_W;
   localparam int unsigned BUS_IDX_W = $clog2(BUS_W);

   typedef logic [BUS_IDX_W-1:0] bus_idx_t;

   typedef enum logic [2:0] {
      StIdle,
      StGetM,
      StGetN,
      StLoadA,
      StLoadB,
      StDone,
      StErr
   } loader_state_e;

   // LSB position of element (r,c) of matrix A (mat=0) or B (mat=1).
   function automatic bus_idx_t elem_offset(input logic mat, input logic [2:0] r,
                                            input logic [2:0] c);
      return bus_idx_t'(int'(mat) * int'(MAT_W)
                        + (int'(r) * int'(DIM_MAX) + int'(c)) * int'(ELEM_W));
   endfunction

   // The whole byte is checked so that e.g. 9 is rejected rather than read as 1.
   function automatic logic dim_ok(input logic [ELEM_W-1:0] v);
      return (v >= ELEM_W'(1)) && (v <= ELEM_W'(DIM_MAX));
   endfunction

endpackage

// File: rtl/matrix_rc_counter.sv
// Row/column position within one matrix, wrapping columns at the loaded width.
// The owner clears it between matrices; last flags the final (rows-1, cols-1) slot.
module matrix_rc_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear_i,
   input  logic       step_i,
   input  logic [2:0] rows_i,
   input  logic [2:0] cols_i,
   output logic [2:0] row_o,
   output logic [2:0] col_o,
   output logic       last_o
);

   logic [2:0] row_q, col_q;

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         row_q <= '0;
         col_q <= '0;
      end else if (step_i) begin
         if (col_q == cols_i - 3'd1) begin
            col_q <= '0;
            row_q <= row_q + 3'd1;
         end else begin
            col_q <= col_q + 3'd1;
         end
      end
   end

   assign row_o  = row_q;
   assign col_o  = col_q;
   assign last_o = (row_q == rows_i - 3'd1) && (col_q == cols_i - 3'd1);

endmodule

// File: rtl/matrix_loader.sv
// Byte-stream loader: dimensions then A and B in row-major order, assembled onto the
// packed dual-matrix bus consumed by AddUnit.
module matrix_loader
   import matrix_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [ELEM_W-1:0] in_data,
   output logic              in_ready,
   output logic [2:0]        m,
   output logic [2:0]        n,
   output logic [BUS_W-1:0]  matrices_in,
   output logic              load_done,
   output logic              dim_err,
   output logic              busy
);

   loader_state_e state;
   logic [2:0]    row, col;
   logic          last_elem;
   logic          loading;
   logic          step;
   logic          rc_clear;

   assign loading  = (state == StLoadA) || (state == StLoadB);
   assign step     = in_valid && loading && !start;
   // Clearing on the last element re-arms the counter for B, and for the next load.
   assign rc_clear = start || (step && last_elem);

   matrix_rc_counter u_rc (
      .clk     (clk),
      .reset   (reset),
      .clear_i (rc_clear),
      .step_i  (step),
      .rows_i  (m),
      .cols_i  (n),
      .row_o   (row),
      .col_o   (col),
      .last_o  (last_elem)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StIdle;
         m           <= '0;
         n           <= '0;
         matrices_in <= '0;
      end else if (start) begin
         state       <= StGetM;
         m           <= '0;
         n           <= '0;
         matrices_in <= '0;
      end else begin
         case (state)
            StGetM: if (in_valid) begin
               if (dim_ok(in_data)) begin
                  m     <= in_data[2:0];
                  state <= StGetN;
               end else begin
                  state <= StErr;
               end
            end
            StGetN: if (in_valid) begin
               if (dim_ok(in_data)) begin
                  n     <= in_data[2:0];
                  state <= StLoadA;
               end else begin
                  state <= StErr;
               end
            end
            StLoadA: if (in_valid) begin
               matrices_in[elem_offset(1'b0, row, col) +: ELEM_W] <= in_data;
               if (last_elem) state <= StLoadB;
            end
            StLoadB: if (in_valid) begin
               matrices_in[elem_offset(1'b1, row, col) +: ELEM_W] <= in_data;
               if (last_elem) state <= StDone;
            end
            default: ;
         endcase
      end
   end

   // Status is decoded from the registered state only; nothing depends on in_valid.
   assign in_ready  = (state == StGetM) || (state == StGetN) || loading;
   assign busy      = in_ready;
   assign load_done = (state == StDone);
   assign dim_err   = (state == StErr);

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: inputs change on the falling edge, outputs are
// checked on the falling edge against hand-built expected buses.
module tb_matrix_loader;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         in_valid;
   logic [7:0]   in_data;
   logic         in_ready;
   logic [2:0]   m;
   logic [2:0]   n;
   logic [399:0] matrices_in;
   logic         load_done;
   logic         dim_err;
   logic         busy;

   int checks = 0;
   int errors = 0;

   matrix_loader dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .m           (m),
      .n           (n),
      .matrices_in (matrices_in),
      .load_done   (load_done),
      .dim_err     (dim_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic st, input logic v, input logic [7:0] d);
      @(negedge clk);
      start    = st;
      in_valid = v;
      in_data  = d;
   endtask

   // Streams bytes; with gaps set, random bounded stall cycles are inserted before each byte.
   task automatic stream(input logic [7:0] q[$], input bit gaps);
      foreach (q[i]) begin
         if (gaps) begin
            for (int g = 0; g < 3; g++) begin
               if ($urandom_range(0, 1) == 0) break;
               drive(1'b0, 1'b0, 8'hEE);
            end
         end
         drive(1'b0, 1'b1, q[i]);
      end
      drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic check_status(input string tag, input logic done, input logic err,
                               input logic rdy);
      chk({tag, "_done"}, 400'(load_done), 400'(done));
      chk({tag, "_err"}, 400'(dim_err), 400'(err));
      chk({tag, "_ready"}, 400'(in_ready), 400'(rdy));
      chk({tag, "_busy"}, 400'(busy), 400'(rdy));
   endtask

   logic [399:0] exp_bus;
   logic [399:0] held_bus;
   logic [7:0]   q[$];
   logic [7:0]   sum;

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      drive(1'b0, 1'b1, 8'h03);
      drive(1'b0, 1'b1, 8'h03);
      check_status("reset", 1'b0, 1'b0, 1'b0);
      chk("reset_bus", matrices_in, '0);
      chk("reset_mn", 400'({m, n}), 400'(6'd0));
      reset = 1'b0;
      drive(1'b0, 1'b1, 8'h02);
      check_status("idle_ignores", 1'b0, 1'b0, 1'b0);

      // 2x3 load, gapless
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
      check_status("start_lat", 1'b0, 1'b0, 1'b1);
      q = '{8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd3, 8'd4, 8'd5,
            8'd3, 8'd3, 8'd3, 8'd2, 8'd2, 8'd2};
      chk("len_2x3", 400'(q.size()), 400'(14));
      stream(q, 1'b0);
      check_status("done_2x3", 1'b1, 1'b0, 1'b0);
      chk("m_2x3", 400'(m), 400'(3'd2));
      chk("n_2x3", 400'(n), 400'(3'd3));
      exp_bus = '0;
      exp_bus[0*8 +: 8] = 8'd1;  exp_bus[1*8 +: 8] = 8'd2;  exp_bus[2*8 +: 8] = 8'd3;
      exp_bus[5*8 +: 8] = 8'd3;  exp_bus[6*8 +: 8] = 8'd4;  exp_bus[7*8 +: 8] = 8'd5;
      exp_bus[25*8 +: 8] = 8'd3; exp_bus[26*8 +: 8] = 8'd3; exp_bus[27*8 +: 8] = 8'd3;
      exp_bus[30*8 +: 8] = 8'd2; exp_bus[31*8 +: 8] = 8'd2; exp_bus[32*8 +: 8] = 8'd2;
      chk("bus_2x3", matrices_in, exp_bus);
      chk("byte0", 400'(matrices_in[7:0]), 400'(8'd1));
      chk("byte7", 400'(matrices_in[63:56]), 400'(8'd5));
      chk("byte25", 400'(matrices_in[207:200]), 400'(8'd3));
      // Element-wise sum as AddUnit would form it: 4 5 6 / 5 6 7
      sum = matrices_in[0 +: 8] + matrices_in[200 +: 8];
      chk("add_00", 400'(sum), 400'(8'd4));
      sum = matrices_in[16 +: 8] + matrices_in[216 +: 8];
      chk("add_02", 400'(sum), 400'(8'd6));
      sum = matrices_in[40 +: 8] + matrices_in[240 +: 8];
      chk("add_10", 400'(sum), 400'(8'd5));
      sum = matrices_in[56 +: 8] + matrices_in[256 +: 8];
      chk("add_12", 400'(sum), 400'(8'd7));
      held_bus = matrices_in;
      drive(1'b0, 1'b1, 8'd99);
      drive(1'b0, 1'b0, 8'd0);
      chk("done_hold_bus", matrices_in, held_bus);
      check_status("done_hold", 1'b1, 1'b0, 1'b0);

      // 5x5 load, A = 1..25, B = 26..50
      drive(1'b1, 1'b0, 8'h00);
      q = '{8'd5, 8'd5};
      for (int i = 1; i <= 50; i++) q.push_back(8'(i));
      stream(q, 1'b0);
      check_status("done_5x5", 1'b1, 1'b0, 1'b0);
      exp_bus = '0;
      for (int i = 0; i < 50; i++) exp_bus[i*8 +: 8] = 8'(i + 1);
      chk("bus_5x5", matrices_in, exp_bus);
      chk("a44", 400'(matrices_in[192 +: 8]), 400'(8'd25));
      chk("b44", 400'(matrices_in[392 +: 8]), 400'(8'd50));

      // Dimension errors
      drive(1'b1, 1'b0, 8'h00);
      q = '{8'd0};
      stream(q, 1'b0);
      check_status("m0", 1'b0, 1'b1, 1'b0);
      chk("m0_bus", matrices_in, '0);
      drive(1'b0, 1'b1, 8'd3);
      drive(1'b0, 1'b0, 8'd0);
      check_status("err_hold", 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 8'h00);
      q = '{8'd2, 8'd6};
      stream(q, 1'b0);
      check_status("n6", 1'b0, 1'b1, 1'b0);
      chk("n6_bus", matrices_in, '0);
      drive(1'b1, 1'b0, 8'h00);
      q = '{8'd9};
      stream(q, 1'b0);
      check_status("m9", 1'b0, 1'b1, 1'b0);
      chk("m9_m", 400'(m), 400'(3'd0));
      chk("m9_bus", matrices_in, '0);
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
      check_status("err_clear", 1'b0, 1'b0, 1'b1);

      // Backpressure: 2x2 with random stalls, A = 1..4, B = 5..8
      q = '{8'd2, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      stream(q, 1'b1);
      check_status("done_bp", 1'b1, 1'b0, 1'b0);
      exp_bus = '0;
      exp_bus[0*8 +: 8] = 8'd1;  exp_bus[1*8 +: 8] = 8'd2;
      exp_bus[5*8 +: 8] = 8'd3;  exp_bus[6*8 +: 8] = 8'd4;
      exp_bus[25*8 +: 8] = 8'd5; exp_bus[26*8 +: 8] = 8'd6;
      exp_bus[30*8 +: 8] = 8'd7; exp_bus[31*8 +: 8] = 8'd8;
      chk("bus_bp", matrices_in, exp_bus);

      // Restart mid-LOAD_A of a 3x3; the byte alongside start is dropped
      drive(1'b1, 1'b0, 8'h00);
      q = '{8'd3, 8'd3, 8'd9, 8'd9, 8'd9, 8'd9};
      foreach (q[i]) drive(1'b0, 1'b1, q[i]);
      drive(1'b1, 1'b1, 8'd9);
      q = '{8'd1, 8'd1, 8'd7, 8'd8};
      stream(q, 1'b0);
      check_status("done_restart", 1'b1, 1'b0, 1'b0);
      exp_bus = '0;
      exp_bus[0*8 +: 8]  = 8'd7;
      exp_bus[25*8 +: 8] = 8'd8;
      chk("bus_restart", matrices_in, exp_bus);
      chk("mn_restart", 400'({m, n}), 400'({3'd1, 3'd1}));

      // Reset during LOAD_B, then a clean 1x2 load
      drive(1'b1, 1'b0, 8'h00);
      q = '{8'd2, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      foreach (q[i]) drive(1'b0, 1'b1, q[i]);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'd6;
      drive(1'b0, 1'b0, 8'h00);
      reset = 1'b0;
      check_status("rst_mid", 1'b0, 1'b0, 1'b0);
      chk("rst_mid_bus", matrices_in, '0);
      chk("rst_mid_mn", 400'({m, n}), 400'(6'd0));
      drive(1'b1, 1'b0, 8'h00);
      q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
      stream(q, 1'b0);
      check_status("done_post_rst", 1'b1, 1'b0, 1'b0);
      exp_bus = '0;
      exp_bus[0*8 +: 8]  = 8'd3; exp_bus[1*8 +: 8]  = 8'd4;
      exp_bus[25*8 +: 8] = 8'd5; exp_bus[26*8 +: 8] = 8'd6;
      chk("bus_post_rst", matrices_in, exp_bus);
      chk("mn_post_rst", 400'({m, n}), 400'({3'd1, 3'd2}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream stage of the matrix adder. Accepts a byte stream over a valid/ready handshake: row count, column count, then matrix A and matrix B elements in row-major order. Assembles them into the 400-bit packed dual-matrix bus, together with `m`/`n`, that `AddUnit` consumes. Out-of-range dimensions are rejected with a held error flag. The bus is cleared on every new load, so unused slots are always zero.

## Interface
- `DIM_MAX`, 5, maximum rows and columns per matrix.
- `ELEM_W`, 8, element width in bits. Bus width is 2·DIM_MAX²·ELEM_W = 400.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse that begins a new load.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `m`  out  3  loaded row count.
- `n`  out  3  loaded column count.
- `matrices_in`  out  400  packed matrices:
  - A element (r,c) at bits [(r·5+c)·8 +: 8];
  - B element (r,c) at bits [200 + (r·5+c)·8 +: 8].
- `load_done`  out  1  level; bus, `m` and `n` are complete and stable.
- `dim_err`  out  1  level; last received dimension was outside 1..5.
- `busy`  out  1  a load is in progress.

## Operation
- States: IDLE, GET_M, GET_N, LOAD_A, LOAD_B, DONE, ERR.
- A transfer occurs when `in_valid && in_ready`.
- `in_ready` = 1 only in GET_M, GET_N, LOAD_A and LOAD_B. It is decoded from the registered state only, with no combinational path from `in_valid`.
- `start` (any state, highest priority after `reset`):
  - clears `matrices_in`, `m`, `n`, `load_done`, `dim_err`;
  - zeroes the row/column counters;
  - next state is GET_M.
- GET_M, on transfer:
  - full 8-bit value in 1..5 → latch into `m`, go to GET_N;
  - otherwise → ERR. No truncation: 8'd9 is an error, not 1.
- GET_N: same rule, latching into `n`; valid value → LOAD_A.
- LOAD_A / LOAD_B, on transfer:
  - write the byte to the slot for (r,c) in A or B;
  - if c == n−1: c←0, r←r+1; else c←c+1.
- Matrix end: at (m−1, n−1), LOAD_A goes to LOAD_B with r=c=0, and LOAD_B goes to DONE.
- A full load is 2 + 2·m·n transfers.
- DONE: `load_done`=1. Bus, `m` and `n` hold until `start` or `reset`.
- ERR: `dim_err`=1. Bus stays zero and the block waits for `start`.
- `busy` = 1 in GET_M through LOAD_B.
- Cycles with `in_valid`=0 (stalls) stall the load with no state change. Bytes presented in IDLE, DONE or ERR are not accepted.

## Timing
- Reset values: all outputs 0; state IDLE.
- `start` sampled at edge t → `in_ready`=1 and `busy`=1 from cycle t+1.
- The final B byte accepted at edge t → `load_done`=1, `busy`=0, `in_ready`=0 from cycle t+1. Each element appears on the bus in the cycle after its transfer.
- Invalid dimension accepted at edge t → `dim_err`=1 from t+1.
- `start` in the same cycle as a transfer: `start` wins and the byte is dropped.
- `reset` mid-load: everything returns to reset values on the next edge. No partial data survives.
- Maximum throughput is one byte per cycle.

## Structure
- Shared package `matrix_pkg`:
  - constants `DIM_MAX`, `ELEM_W`, `MAT_W`=200, `BUS_W`=400;
  - loader state enum;
  - element-offset function (mat, r, c) → bit index.
- `AddUnit` must use the same package constants.
- Sub-module `matrix_rc_counter`: row/column counter with `n`-wrap and a last-element flag. One instance is shared by LOAD_A and LOAD_B, cleared on matrix change.

## Test plan
- 2×3 load. Stream after `start`: 2,3 | A 1,2,3,3,4,5 | B 3,3,3,2,2,2. Required:
  - `load_done` after 14 transfers; `m`=2, `n`=3;
  - bus byte 0 = 1, byte 7 = 5, byte 25 = 3;
  - all unused bytes 0;
  - downstream `AddUnit` outputs 4 5 6 / 5 6 7.
- 5×5 load of values 1..25 for A and 26..50 for B. Required: every slot filled; A(4,4) at bits [192+:8] = 25; B(4,4) at bits [392+:8] = 50.
- Dimension errors:
  - `m`=0 → `dim_err`=1, `in_ready`=0, bus zero;
  - `n`=6 → same response;
  - `m`=9 → same response;
  - a following `start` clears `dim_err`.
- Backpressure: 2×2 load with `in_valid` toggled randomly. Result is identical to a gapless load, and no byte is duplicated or skipped.
- Restart: `start` issued mid-LOAD_A of a 3×3 load, followed by a 1×1 load (A=7, B=8). Required: bus holds only bytes 0 = 7 and 25 = 8; `m`=`n`=1.
- `reset` asserted in LOAD_B → all outputs 0 on the next cycle; a subsequent full load is correct.
